// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/LSU memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // True when funct3 names a supported load (we=0) or store (we=1).
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_lane_align.sv
// Byte-lane placement for stores and extract/extend for loads.
module mem_lane_align
    import mem_port_arbiter_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wlanes,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    // Store data is replicated across lanes; the mask picks the live ones.
    always_comb begin
        wmask  = 4'b1111;
        wlanes = wdata;
        case (funct3[1:0])
            2'b00: begin
                wmask  = 4'b0001 << offset;
                wlanes = {4{wdata[7:0]}};
            end
            2'b01: begin
                wmask  = 4'b0011 << offset;
                wlanes = {2{wdata[15:0]}};
            end
            default: begin
                wmask  = 4'b1111;
                wlanes = wdata;
            end
        endcase
    end

    // Load result: select the addressed byte/halfword and extend it.
    always_comb begin
        rdata_ext = rdata;
        case (funct3)
            F3_LB:   rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  rdata_ext = {24'd0, shifted[7:0]};
            F3_LHU:  rdata_ext = {16'd0, shifted[15:0]};
            default: rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch and LSU.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MEM_AW = 8,
    parameter int unsigned XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [XLEN-1:0]   i_req_addr,
    output logic              i_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [XLEN-1:0]   i_rsp_data,
    output logic              i_rsp_err,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [XLEN-1:0]   d_req_addr,
    input  logic              d_req_we,
    input  logic [2:0]        d_req_funct3,
    input  logic [XLEN-1:0]   d_req_wdata,
    output logic              d_rsp_valid,
    input  logic              d_rsp_ready,
    output logic [XLEN-1:0]   d_rsp_data,
    output logic              d_rsp_err,
    output logic              mem_request,
    output logic              mem_we_re,
    output logic [MEM_AW-1:0] mem_address,
    output logic [XLEN-1:0]   mem_w_data,
    output logic [3:0]        mem_masking,
    input  logic [XLEN-1:0]   mem_r_data
);

    state_t              state;
    owner_t              owner_q;
    owner_t              last_grant;
    logic [MEM_AW+1:0]   addr_q;
    logic                we_q;
    logic [2:0]          f3_q;
    logic [XLEN-1:0]     wdata_q;
    logic [XLEN-1:0]     rsp_data_q;
    logic                rsp_err_q;

    logic                grant_i;
    logic                grant_d;
    logic [XLEN-1:0]     sel_addr;
    logic                req_err;
    logic [3:0]          wmask;
    logic [XLEN-1:0]     wlanes;
    logic [XLEN-1:0]     rdata_ext;
    logic                access;
    logic                store_access;
    logic                resp;

    // Round-robin grant, only offered while idle.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == ST_IDLE) begin
            if (i_req_valid && d_req_valid) begin
                grant_i = (last_grant == OWN_D);
                grant_d = (last_grant == OWN_I);
            end else begin
                grant_i = i_req_valid;
                grant_d = d_req_valid;
            end
        end
    end

    assign i_req_ready = grant_i;
    assign d_req_ready = grant_d;
    assign sel_addr    = grant_i ? i_req_addr : d_req_addr;

    // Range, alignment and funct3 legality of the request being granted.
    always_comb begin
        req_err = |sel_addr[XLEN-1:MEM_AW+2];
        if (grant_i) begin
            if (|sel_addr[1:0]) req_err = 1'b1;
        end else begin
            if (!f3_legal(d_req_we, d_req_funct3)) req_err = 1'b1;
            if (d_req_funct3[1:0] == 2'b10 && |sel_addr[1:0]) req_err = 1'b1;
            if (d_req_funct3[1:0] == 2'b01 && sel_addr[0]) req_err = 1'b1;
        end
    end

    mem_lane_align u_align (
        .funct3    (f3_q),
        .offset    (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (mem_r_data),
        .wmask     (wmask),
        .wlanes    (wlanes),
        .rdata_ext (rdata_ext)
    );

    // Memory strobes are decoded from state so reset kills an access at once.
    assign access       = (state == ST_ACCESS);
    assign store_access = access && we_q;
    assign mem_request  = access;
    assign mem_we_re    = !store_access;
    assign mem_address  = access ? addr_q[MEM_AW+1:2] : '0;
    assign mem_w_data   = store_access ? wlanes : '0;
    assign mem_masking  = store_access ? wmask : 4'b0000;

    assign resp        = (state == ST_RESP);
    assign i_rsp_valid = resp && (owner_q == OWN_I);
    assign d_rsp_valid = resp && (owner_q == OWN_D);
    assign i_rsp_data  = i_rsp_valid ? rsp_data_q : '0;
    assign d_rsp_data  = d_rsp_valid ? rsp_data_q : '0;
    assign i_rsp_err   = i_rsp_valid && rsp_err_q;
    assign d_rsp_err   = d_rsp_valid && rsp_err_q;

    // Request/access/response sequencer with latched request fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            owner_q    <= OWN_I;
            last_grant <= OWN_D;
            addr_q     <= '0;
            we_q       <= 1'b0;
            f3_q       <= F3_LW;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_i || grant_d) begin
                        owner_q    <= grant_i ? OWN_I : OWN_D;
                        last_grant <= grant_i ? OWN_I : OWN_D;
                        addr_q     <= sel_addr[MEM_AW+1:0];
                        we_q       <= grant_d && d_req_we;
                        f3_q       <= grant_i ? F3_LW : d_req_funct3;
                        wdata_q    <= grant_i ? '0 : d_req_wdata;
                        rsp_data_q <= '0;
                        rsp_err_q  <= req_err;
                        state      <= req_err ? ST_RESP : ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    rsp_data_q <= we_q ? '0 : rdata_ext;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if ((owner_q == OWN_I) ? i_rsp_ready : d_rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 256x32 instruction/data memory between the instruction-fetch unit (read-only port "i") and the load/store unit (port "d").
- Arbitrates between the two requesters with a round-robin policy.
- Sequences each access through a request/access/response FSM.
- Generates byte masks and write-lane placement for stores, and extracts and sign-extends load data.
- Sits between the core front-end/LSU and the memory block; it is the only master on the memory interface.

Parameters:
- MEM_AW, 8, word-address width of the memory (depth 2**MEM_AW words).
- XLEN, 32, data and byte-address width.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_req_valid  in  1  fetch request valid
- i_req_ready  out  1  fetch request accepted this cycle
- i_req_addr  in  XLEN  fetch byte address
- i_rsp_valid  out  1  fetch response valid
- i_rsp_ready  in  1  fetch response consumed
- i_rsp_data  out  XLEN  fetched word
- i_rsp_err  out  1  misaligned or out-of-range fetch
- d_req_valid  in  1  load/store request valid
- d_req_ready  out  1  load/store request accepted
- d_req_addr  in  XLEN  byte address
- d_req_we  in  1  1 = store, 0 = load
- d_req_funct3  in  3  RV32 width/sign code
- d_req_wdata  in  XLEN  store data, right-aligned
- d_rsp_valid  out  1  load/store response valid
- d_rsp_ready  in  1  response consumed
- d_rsp_data  out  XLEN  extended load data; 0 for stores
- d_rsp_err  out  1  misaligned, out-of-range or illegal funct3
- mem_request  out  1  memory access strobe
- mem_we_re  out  1  0 = write, 1 = read; idle value 1
- mem_address  out  MEM_AW  word index
- mem_w_data  out  XLEN  lane-placed store data
- mem_masking  out  4  byte-lane write enables
- mem_r_data  in  XLEN  combinational read data from memory

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset (async, immediate):
  - state=IDLE, last_grant=D, so port i wins the first conflict.
  - All rsp_valid/rsp_err/rsp_data = 0.
  - mem_request=0, mem_we_re=1, mem_masking=0, mem_address=0, mem_w_data=0.
  - Reset during ACCESS suppresses the write that cycle, because mem_request is decoded from state.
- IDLE arbitration:
  - Only one valid request: grant it.
  - Both valid: grant the port opposite last_grant.
  - i_req_ready / d_req_ready are high only in IDLE and only for the granted port; at most one is high per cycle.
  - On accept, latch addr, we, funct3, wdata and owner; update last_grant.
- Error check at accept (no memory access; go straight to RESP with err=1, data=0):
  - addr[XLEN-1:MEM_AW+2] != 0.
  - Word access with addr[1:0] != 0.
  - Halfword access with addr[0] = 1.
  - Fetch with addr[1:0] != 0.
  - Load funct3 not in {000, 001, 010, 100, 101}.
  - Store funct3 not in {000, 001, 010}.
- Legal requests go to ACCESS, which lasts exactly 1 cycle:
  - mem_request=1, mem_address=addr[MEM_AW+1:2].
  - Reads: mem_we_re=1, mem_masking=0.
  - Stores: mem_we_re=0.
    - SB: wdata[7:0] replicated to all 4 lanes, mask = 0001 << addr[1:0].
    - SH: wdata[15:0] replicated to both halves, mask = 0011 << addr[1:0].
    - SW: mask=1111.
  - Reads capture mem_r_data into the response register at the end of ACCESS.
- Load extraction:
  - Byte/halfword selected by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Fetch returns the raw word.
- RESP: owner's rsp_valid=1; data and err held stable until owner's rsp_ready=1, then go to IDLE.
  - The non-owner's rsp_valid stays 0.
- Latency: accept at cycle N -> rsp_valid from N+2 (error: N+1).
- Peak throughput: one access per 3 cycles.
- New requests are not accepted in ACCESS or RESP; requesters hold valid and their fields stable until ready.
- Stores complete (memory written at the ACCESS clock edge) before d_rsp_valid rises.

Decomposition:
- Shared package holds:
  - FSM state encoding.
  - Port-owner enum (I, D).
  - funct3 constants: LB, LH, LW, LBU, LHU, SB, SH, SW.
- One sub-module is natural: mem_lane_align.
  - Combinational.
  - Store mask/data placement and load extract/extend from funct3 + addr[1:0].

Test Plan:
- Fetch only, i_req_addr=0x10, mem[4]=0xDEADBEEF -> i_req_ready at N; mem_request=1, mem_we_re=1, mem_address=4 at N+1; i_rsp_valid, i_rsp_data=0xDEADBEEF at N+2.
- SB addr=0x0D, wdata=0x000000A5 -> ACCESS: mem_we_re=0, mem_address=3, mem_masking=0010, mem_w_data=0xA5A5A5A5; subsequent LB 0x0D -> 0xFFFFFFA5, LBU -> 0x000000A5.
- SH addr=0x06, wdata=0x8001, then LH 0x06 -> masking=1100, lanes 0x80018001; load returns 0xFFFF8001.
- Both valid every cycle, held 4 transactions -> grants i, d, i, d; never both ready in one cycle; responses routed only to the owner.
- LW addr=0x02, SH addr=0x03, load funct3=011, fetch addr=0x400 -> each: no mem_request, d/i_rsp_err=1, data=0, rsp_valid at N+1.
- Assert rst during a store's ACCESS cycle -> mem_request drops immediately, target word unchanged, all rsp_valid=0; after release, first conflict grants i.
